pc_trap_unit: RTL
=================

# pc_trap_unit

Parametrised program-counter register with a trap vector and a nested return-address stack. It is the successor to the fixed single-vector PC register and sits in the fetch stage of the RISC-V core. It holds the current PC and selects among reset vector, trap vector, trap return and the next-PC input. Taking a trap saves the return address on a small LIFO, and a return pops it, so nested traps resume correctly.

## Interface
Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0, PC value on reset.
- TRAP_VEC, 32'h30, PC value loaded when a trap is taken.
- EPC_DEPTH, 4, return-stack entries (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  PC update enable; 0 = stall.
- trg  in  1  trap request.
- mret  in  1  trap return request.
- PC_Next_i  in  WIDTH  next PC from the fetch/branch logic.
- PC_o  out  WIDTH  current PC (registered).
- EPC_o  out  WIDTH  top of the return stack; 0 when the stack is empty.
- depth_o  out  $clog2(EPC_DEPTH+1)  number of valid stack entries.
- overflow_o  out  1  sticky; a trap was taken with the stack full.
- underflow_o  out  1  sticky; mret was seen with the stack empty.

## Operation
- The following priority is evaluated every clock edge. The first matching row acts:
  1. rst: PC_o=RESET_VEC, stack cleared, depth_o=0, both sticky flags cleared.
  2. trap accepted (trg, see Configuration):
     - PC_o<=TRAP_VEC.
     - Push PC_Next_i as the return address.
     - If depth_o==EPC_DEPTH, the push is discarded, the existing entries are unchanged, overflow_o<=1, and the PC still jumps to TRAP_VEC.
  3. mret:
     - If depth_o>0: PC_o<=EPC_o (top entry), pop, depth_o decrements.
     - If empty: PC_o<=PC_Next_i, underflow_o<=1, depth unchanged.
  4. en=0: PC_o holds its value; the stack is unchanged.
  5. Otherwise: PC_o<=PC_Next_i.
- trg and mret override the stall: both act even when en=0.
- trg and mret in the same cycle: the trap wins and mret is dropped. There is no pop, and no underflow is flagged.
- Sticky flags clear only on rst.
- Stack storage is a register array indexed by depth_o. The top entry is index depth_o-1.
- Arithmetic on depth_o never wraps. It saturates at 0 and EPC_DEPTH by the rules above.

## Timing
- All state is registered on the rising clk edge. An input in cycle N is visible on PC_o, depth_o and the flags in cycle N+1. Latency is 1.
- EPC_o, depth_o, overflow_o and underflow_o are combinational from registers only. No input-to-output combinational path exists.
- Reset is asynchronous. Asserting rst mid-trap or mid-return forces the outputs to their reset values immediately, independent of clk:
  - PC_o=RESET_VEC
  - EPC_o=0
  - depth_o=0
  - overflow_o=0
  - underflow_o=0
- On the first clock edge after rst deasserts, normal priority applies.
- Back-to-back traps push on consecutive cycles. A trap followed immediately by mret returns to the just-pushed address.

## Configuration
- PC_TRG_EDGE_EN:
  - When defined: a registered copy of trg is kept, with reset value 0. A trap is accepted only on a rising edge (trg=1 and previous trg=0). A trg held high for several cycles takes exactly one trap. In the following cycles, priority falls through to mret/stall/next.
  - When undefined: a trap is accepted in every cycle trg=1, so a held trg re-traps and pushes every cycle.

## Test plan
- Reset: pulse rst between clock edges with RESET_VEC=0 -> PC_o=0, depth_o=0 and flags 0 immediately, without waiting for a clock edge.
- Sequential plus stall: PC_Next_i=4, 8, 12 with en=1,0,1 -> PC_o=4, 4, 12. The stack is untouched.
- Nested trap/return:
  - PC_Next_i=0x100 with trg, then 0x34 with trg -> PC_o=0x30 both times, depth_o=2, EPC_o=0x34.
  - Then mret twice -> PC_o=0x34, then 0x100, depth_o=0.
- Overflow/underflow with EPC_DEPTH=4:
  - Five traps -> depth_o=4, overflow_o=1, PC_o=0x30.
  - Five mrets -> four pops return in reverse order. The fifth gives PC_o=PC_Next_i and underflow_o=1.
- Simultaneous and held trg:
  - trg=mret=1 with depth_o=1 -> PC_o=0x30, depth_o=2, underflow_o stays 0.
  - trg held for 3 cycles -> depth +1 with PC_TRG_EDGE_EN, depth +3 without.

Source files
------------

// File: rtl/pc_trap_unit_if.sv
// Fetch-stage PC/trap bus: control requests and next PC in, PC and return-stack status out.
interface pc_trap_unit_if #(
  parameter int WIDTH     = 32,
  parameter int EPC_DEPTH = 4
);
  localparam int DW = $clog2(EPC_DEPTH + 1);

  logic             en;
  logic             trg;
  logic             mret;
  logic [WIDTH-1:0] PC_Next_i;
  logic [WIDTH-1:0] PC_o;
  logic [WIDTH-1:0] EPC_o;
  logic [DW-1:0]    depth_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output en, trg, mret, PC_Next_i,
    input  PC_o, EPC_o, depth_o, overflow_o, underflow_o
  );

  modport slave (
    input  en, trg, mret, PC_Next_i,
    output PC_o, EPC_o, depth_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/pc_trap_unit.sv
// PC register with trap vector and nested return-address LIFO.
// Define PC_TRG_EDGE_EN to accept traps only on a rising edge of trg.
module pc_trap_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h30),
  parameter int               EPC_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_trap_unit_if.slave bus
);
  localparam int DW = $clog2(EPC_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(EPC_DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] stack [EPC_DEPTH];
  logic [DW-1:0]    depth;
  logic             ovf;
  logic             unf;
  logic             trap_acc;
  logic             full;
  logic             empty;
  logic             push;

`ifdef PC_TRG_EDGE_EN
  logic trg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trg_q <= 1'b0;
    else     trg_q <= bus.trg;
  end

  assign trap_acc = bus.trg & ~trg_q;
`else
  assign trap_acc = bus.trg;
`endif

  assign full  = (depth == FULL);
  assign empty = (depth == '0);
  assign push  = trap_acc & ~full;

  // Top of stack lives at index depth-1; an empty stack reads as zero.
  always_comb begin
    epc = '0;
    for (int unsigned i = 0; i < EPC_DEPTH; i++) begin
      if (depth == DW'(i + 1)) epc = stack[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < EPC_DEPTH; i++) stack[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < EPC_DEPTH; i++) begin
        if (push && depth == DW'(i)) stack[i] <= bus.PC_Next_i;
      end
    end
  end

  // Trap beats mret beats stall; trap and mret both ignore en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_VEC;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (trap_acc) begin
      pc <= TRAP_VEC;
      if (full) ovf   <= 1'b1;
      else      depth <= depth + DW'(1);
    end else if (bus.mret) begin
      if (!empty) begin
        pc    <= epc;
        depth <= depth - DW'(1);
      end else begin
        pc  <= bus.PC_Next_i;
        unf <= 1'b1;
      end
    end else if (bus.en) begin
      pc <= bus.PC_Next_i;
    end
  end

  assign bus.PC_o        = pc;
  assign bus.EPC_o       = epc;
  assign bus.depth_o     = depth;
  assign bus.overflow_o  = ovf;
  assign bus.underflow_o = unf;
endmodule
